// File: rtl/arbiter_game_led_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : arbiter_game_led_decoder_if
//  Brief    : LED bus plus decoded game-event outputs of the LED decoder.
//  Revision : 1.0  initial release
// ============================================================================
interface arbiter_game_led_decoder_if #(
    parameter int SCORE_W = 8
);
    logic [3:0]         leds_in;
    logic [2:0]         step_out;
    logic               go_out;
    logic               winner_valid_out;
    logic [1:0]         winner_id_out;
    logic [SCORE_W-1:0] score1_out;
    logic [SCORE_W-1:0] score2_out;
    logic               error_out;

    // master drives the LED bus and consumes events; slave is the decoder
    modport master (
        output leds_in,
        input  step_out, go_out, winner_valid_out, winner_id_out,
        input  score1_out, score2_out, error_out
    );

    modport slave (
        input  leds_in,
        output step_out, go_out, winner_valid_out, winner_id_out,
        output score1_out, score2_out, error_out
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_game_led_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : arbiter_game_led_decoder
//  Brief    : Passive LED-bus monitor that recovers countdown, go, winner,
//             per-player scores and protocol errors of the arbiter game.
//  Revision : 1.0  initial release
// ============================================================================
module arbiter_game_led_decoder #(
    parameter int TOGGLES = 4,
    parameter int TIMEOUT = 4096,
    parameter int SCORE_W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_in,
    arbiter_game_led_decoder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CD    = 3'd1,
        S_ARMED = 3'd2,
        S_SHIFT = 3'd3,
        S_TRACK = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam int                 c_tmo_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
    localparam logic [2:0]         c_toggles  = 3'(TOGGLES);
    localparam logic [SCORE_W-1:0] c_score_1  = SCORE_W'(1);

    function automatic logic [3:0] step_pat(input logic [2:0] k);
        case (k)
            3'd4:    step_pat = 4'b1111;
            3'd3:    step_pat = 4'b0111;
            3'd2:    step_pat = 4'b0011;
            3'd1:    step_pat = 4'b0001;
            default: step_pat = 4'b0000;
        endcase
    endfunction

    // bit 3 is the leftmost LED, so a left rotate moves the lit LED upward
    function automatic logic [3:0] rotl(input logic [3:0] x);
        rotl = {x[2:0], x[3]};
    endfunction

    function automatic logic [3:0] rotr(input logic [3:0] x);
        rotr = {x[0], x[3:1]};
    endfunction

    state_t             r_state, w_state_n;
    logic [3:0]         r_cur, r_prev;
    logic [2:0]         r_step, w_step_n;
    logic [2:0]         r_blink, w_blink_n;
    logic [3:0]         r_start, w_start_n;
    logic [1:0]         r_winner, w_winner_n;
    logic [SCORE_W-1:0] r_score1, w_score1_n;
    logic [SCORE_W-1:0] r_score2, w_score2_n;
    logic               r_err, w_err_n;
    logic               r_go, w_go_n;
    logic               r_wv, w_wv_n;
    logic [c_tmo_w-1:0] r_tmo, w_tmo_n;

    logic w_changed, w_rise_all, w_tmo_active, w_tmo_hit, w_onehot;

    assign w_changed    = (r_cur != r_prev);
    assign w_rise_all   = (r_cur == 4'b1111) && (r_prev != 4'b1111);
    assign w_tmo_active = (r_state == S_CD) || (r_state == S_SHIFT) || (r_state == S_TRACK);
    assign w_tmo_hit    = w_tmo_active && !w_changed && (r_tmo == c_tmo_last);
    assign w_onehot     = (r_cur != 4'b0000) && ((r_cur & (r_cur - 4'd1)) == 4'b0000);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_cur    <= 4'b0000;
            r_prev   <= 4'b0000;
            r_step   <= 3'd0;
            r_blink  <= 3'd0;
            r_start  <= 4'b0000;
            r_winner <= 2'd0;
            r_score1 <= '0;
            r_score2 <= '0;
            r_err    <= 1'b0;
            r_go     <= 1'b0;
            r_wv     <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cur    <= bus.leds_in;
            r_prev   <= r_cur;
            r_step   <= w_step_n;
            r_blink  <= w_blink_n;
            r_start  <= w_start_n;
            r_winner <= w_winner_n;
            r_score1 <= w_score1_n;
            r_score2 <= w_score2_n;
            r_err    <= w_err_n;
            r_go     <= w_go_n;
            r_wv     <= w_wv_n;
            r_tmo    <= w_tmo_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_step_n   = r_step;
        w_blink_n  = r_blink;
        w_start_n  = r_start;
        w_winner_n = r_winner;
        w_score1_n = r_score1;
        w_score2_n = r_score2;
        w_err_n    = r_err;
        w_go_n     = 1'b0;
        w_wv_n     = 1'b0;
        w_tmo_n    = (w_changed || !w_tmo_active) ? '0 : r_tmo + c_tmo_one;

        // a fresh all-on edge is a game (re)start, except while already counting step 4
        if (w_rise_all && !((r_state == S_CD) && (r_step == 3'd4))) begin
            w_state_n  = S_CD;
            w_step_n   = 3'd4;
            w_blink_n  = 3'd1;
            w_winner_n = 2'd0;
            w_err_n    = 1'b0;
        end else if (w_tmo_hit) begin
            w_state_n = S_ERROR;
            w_step_n  = 3'd0;
            w_err_n   = 1'b1;
        end else begin
            case (r_state)
                S_CD: begin
                    if ((r_step == 3'd1) && (r_blink == c_toggles) && (r_cur == 4'b0000)) begin
                        w_state_n = S_ARMED;
                        w_step_n  = 3'd0;
                        w_go_n    = 1'b1;
                    end else if (r_cur == 4'b0000) begin
                        w_state_n = S_CD;
                    end else if (r_cur == step_pat(r_step)) begin
                        if (w_changed && (r_blink != 3'd7))
                            w_blink_n = r_blink + 3'd1;
                    end else if ((r_cur == step_pat(r_step - 3'd1)) && w_changed &&
                                 (r_blink == c_toggles)) begin
                        w_step_n  = r_step - 3'd1;
                        w_blink_n = 3'd1;
                    end else begin
                        w_state_n = S_ERROR;
                        w_step_n  = 3'd0;
                        w_err_n   = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_onehot) begin
                        w_start_n = r_cur;
                        w_state_n = S_SHIFT;
                    end else if (r_cur != 4'b0000) begin
                        w_state_n = S_ERROR;
                        w_err_n   = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_cur == rotl(r_start)) begin
                        w_winner_n = 2'd1;
                        w_wv_n     = 1'b1;
                        w_state_n  = S_TRACK;
                        if (r_score1 != '1)
                            w_score1_n = r_score1 + c_score_1;
                    end else if (r_cur == rotr(r_start)) begin
                        w_winner_n = 2'd2;
                        w_wv_n     = 1'b1;
                        w_state_n  = S_TRACK;
                        if (r_score2 != '1)
                            w_score2_n = r_score2 + c_score_1;
                    end else if (r_cur != r_start) begin
                        w_state_n = S_ERROR;
                        w_err_n   = 1'b1;
                    end
                end
                S_TRACK: begin
                    if (w_changed) begin
                        if (r_cur == 4'b0000) begin
                            w_state_n = S_IDLE;
                        end else if (r_cur != ((r_winner == 2'd1) ? rotl(r_prev) : rotr(r_prev))) begin
                            w_state_n = S_ERROR;
                            w_err_n   = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_n = r_state;
                end
            endcase
        end
    end

    assign bus.step_out         = r_step;
    assign bus.go_out           = r_go;
    assign bus.winner_valid_out = r_wv;
    assign bus.winner_id_out    = r_winner;
    assign bus.score1_out       = r_score1;
    assign bus.score2_out       = r_score2;
    assign bus.error_out        = r_err;

endmodule
`default_nettype wire
